// File: rtl/i2c_cmd_sequencer.sv
// Command front-end for the I2C master: queues requests in a small FIFO,
// issues them one at a time, retries on NACK, guards against a hung master
// and hands back a held response.
module i2c_cmd_sequencer #(
    parameter int DEPTH    = 4,
    parameter int RETRIES  = 2,
    parameter int START_TO = 15,
    parameter int DONE_TO  = 255
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     cmd_valid,
    output logic                     cmd_ready,
    input  logic [6:0]               cmd_addr,
    input  logic [4:0]               cmd_mem,
    input  logic                     cmd_rw,
    input  logic [7:0]               cmd_data,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [7:0]               rsp_data,
    output logic                     rsp_nack,
    output logic                     rsp_timeout,
    output logic [1:0]               rsp_tries,
    output logic                     m_en,
    output logic [6:0]               m_addr,
    output logic [4:0]               m_mem_addr,
    output logic                     m_rw,
    output logic [7:0]               m_data_wr,
    input  logic [7:0]               m_data_rd,
    input  logic                     m_ack_err,
    input  logic                     m_busy,
    output logic [$clog2(DEPTH):0]   fifo_level,
    output logic                     idle
);
    localparam int AW   = $clog2(DEPTH);
    localparam int LW   = AW + 1;
    localparam int TMAX = (START_TO > DONE_TO) ? START_TO : DONE_TO;
    localparam int TW   = $clog2(TMAX + 1);
    localparam int EW   = 21;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_ISSUE     = 3'd1,
        S_WAIT_BUSY = 3'd2,
        S_WAIT_DONE = 3'd3,
        S_CHECK     = 3'd4,
        S_GAP       = 3'd5,
        S_RESP      = 3'd6
    } state_t;

    state_t          r_state;
    state_t          w_next;
    logic [EW-1:0]   r_mem [DEPTH];
    logic [AW-1:0]   r_wptr;
    logic [AW-1:0]   r_rptr;
    logic [LW-1:0]   r_level;
    logic [TW-1:0]   r_timer;
    logic [1:0]      r_tries;
    logic            r_to;
    logic            r_m_en;
    logic [6:0]      r_m_addr;
    logic [4:0]      r_m_mem;
    logic            r_m_rw;
    logic [7:0]      r_m_data;
    logic            r_rsp_valid;
    logic [7:0]      r_rsp_data;
    logic            r_rsp_nack;
    logic            r_rsp_timeout;
    logic [1:0]      r_rsp_tries;

    logic            w_cmd_ready;
    logic            w_empty;
    logic            w_push;
    logic            w_pop;
    logic            w_tmr_clr;
    logic            w_tmr_inc;
    logic            w_try_inc;
    logic            w_set_to;

    assign w_cmd_ready = (r_level != LW'(DEPTH));
    assign w_empty     = (r_level == '0);
    assign w_push      = cmd_valid && w_cmd_ready;

    // FSM state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state decode plus the one-cycle control strobes for the datapath.
    // A new attempt is only launched while the master reports idle, which also
    // covers the case where a previous transaction timed out on a hung master.
    always_comb begin
        w_next    = r_state;
        w_pop     = 1'b0;
        w_tmr_clr = 1'b0;
        w_tmr_inc = 1'b0;
        w_try_inc = 1'b0;
        w_set_to  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (!w_empty && !r_rsp_valid && !m_busy) begin
                    w_next = S_ISSUE;
                    w_pop  = 1'b1;
                end else begin
                    w_next = S_IDLE;
                end
            end
            S_ISSUE: begin
                w_next    = S_WAIT_BUSY;
                w_tmr_clr = 1'b1;
            end
            S_WAIT_BUSY: begin
                if (m_busy) begin
                    w_next    = S_WAIT_DONE;
                    w_tmr_clr = 1'b1;
                end else if (r_timer == TW'(START_TO - 1)) begin
                    w_next   = S_RESP;
                    w_set_to = 1'b1;
                end else begin
                    w_tmr_inc = 1'b1;
                end
            end
            S_WAIT_DONE: begin
                if (!m_busy) begin
                    w_next = S_CHECK;
                end else if (r_timer == TW'(DONE_TO - 1)) begin
                    w_next   = S_RESP;
                    w_set_to = 1'b1;
                end else begin
                    w_tmr_inc = 1'b1;
                end
            end
            S_CHECK: begin
                if (m_ack_err && (r_tries < 2'(RETRIES))) begin
                    w_next    = S_GAP;
                    w_try_inc = 1'b1;
                end else begin
                    w_next = S_RESP;
                end
            end
            S_GAP: begin
                if (!m_busy) begin
                    w_next = S_ISSUE;
                end else begin
                    w_next = S_GAP;
                end
            end
            S_RESP: begin
                w_next = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    // FIFO storage; contents need no reset because the level gates every read.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wptr] <= {cmd_addr, cmd_mem, cmd_rw, cmd_data};
        end
    end

    // FIFO pointers and occupancy; pointers wrap naturally at DEPTH.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_level <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + AW'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + AW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + LW'(1);
                2'b01:   r_level <= r_level - LW'(1);
                default: r_level <= r_level;
            endcase
        end
    end

    // Attempt bookkeeping: watchdog timer, retry count and timeout flag.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_timer <= '0;
            r_tries <= 2'd0;
            r_to    <= 1'b0;
        end else begin
            if (w_tmr_clr) begin
                r_timer <= '0;
            end else if (w_tmr_inc) begin
                r_timer <= r_timer + TW'(1);
            end
            if (w_pop) begin
                r_tries <= 2'd0;
                r_to    <= 1'b0;
            end else begin
                if (w_try_inc) begin
                    r_tries <= r_tries + 2'd1;
                end
                if (w_set_to) begin
                    r_to <= 1'b1;
                end
            end
        end
    end

    // Master-side request: fields latch on pop and persist; enable is a 1-cycle strobe.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_m_en   <= 1'b0;
            r_m_addr <= 7'd0;
            r_m_mem  <= 5'd0;
            r_m_rw   <= 1'b0;
            r_m_data <= 8'd0;
        end else begin
            r_m_en <= (w_next == S_ISSUE);
            if (w_pop) begin
                {r_m_addr, r_m_mem, r_m_rw, r_m_data} <= r_mem[r_rptr];
            end
        end
    end

    // Response holding register; loaded in RESP, released on rsp_ready.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rsp_valid   <= 1'b0;
            r_rsp_data    <= 8'd0;
            r_rsp_nack    <= 1'b0;
            r_rsp_timeout <= 1'b0;
            r_rsp_tries   <= 2'd0;
        end else if (r_state == S_RESP) begin
            r_rsp_valid   <= 1'b1;
            r_rsp_timeout <= r_to;
            r_rsp_nack    <= !r_to && m_ack_err;
            r_rsp_tries   <= r_tries;
            r_rsp_data    <= (!r_to && !m_ack_err && !r_m_rw) ? m_data_rd : 8'h00;
        end else if (r_rsp_valid && rsp_ready) begin
            r_rsp_valid <= 1'b0;
        end
    end

    assign cmd_ready   = w_cmd_ready;
    assign fifo_level  = r_level;
    assign idle        = w_empty && (r_state == S_IDLE) && !r_rsp_valid;
    assign m_en        = r_m_en;
    assign m_addr      = r_m_addr;
    assign m_mem_addr  = r_m_mem;
    assign m_rw        = r_m_rw;
    assign m_data_wr   = r_m_data;
    assign rsp_valid   = r_rsp_valid;
    assign rsp_data    = r_rsp_data;
    assign rsp_nack    = r_rsp_nack;
    assign rsp_timeout = r_rsp_timeout;
    assign rsp_tries   = r_rsp_tries;
endmodule

// File: tb/tb_i2c_cmd_sequencer.sv
// Bench for i2c_cmd_sequencer: a behavioural I2C master responder, a response
// scoreboard fed by the stimulus, and directed test sequences.
module tb_i2c_cmd_sequencer;
    localparam int DEPTH    = 4;
    localparam int RETRIES  = 2;
    localparam int START_TO = 15;
    localparam int DONE_TO  = 255;

    logic       clk;
    logic       rst;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [6:0] cmd_addr;
    logic [4:0] cmd_mem;
    logic       cmd_rw;
    logic [7:0] cmd_data;
    logic       rsp_valid;
    logic       rsp_ready;
    logic [7:0] rsp_data;
    logic       rsp_nack;
    logic       rsp_timeout;
    logic [1:0] rsp_tries;
    logic       m_en;
    logic [6:0] m_addr;
    logic [4:0] m_mem_addr;
    logic       m_rw;
    logic [7:0] m_data_wr;
    logic [7:0] m_data_rd;
    logic       m_ack_err;
    logic       m_busy;
    logic [2:0] fifo_level;
    logic       idle;

    int          errors = 0;
    int          checks = 0;
    int          en_cnt = 0;
    int          mode = 0;          // 0 normal, 1 busy never rises, 2 busy stuck high
    int          nack_left = 0;
    logic [7:0]  rd_base = 8'h5C;
    logic        stuck_release = 1'b0;
    logic [11:0] exp_q[$];          // {data, nack, timeout, tries}

    i2c_cmd_sequencer #(.DEPTH(DEPTH), .RETRIES(RETRIES), .START_TO(START_TO), .DONE_TO(DONE_TO)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr), .cmd_mem(cmd_mem),
        .cmd_rw(cmd_rw), .cmd_data(cmd_data),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_nack(rsp_nack),
        .rsp_timeout(rsp_timeout), .rsp_tries(rsp_tries),
        .m_en(m_en), .m_addr(m_addr), .m_mem_addr(m_mem_addr), .m_rw(m_rw), .m_data_wr(m_data_wr),
        .m_data_rd(m_data_rd), .m_ack_err(m_ack_err), .m_busy(m_busy),
        .fifo_level(fifo_level), .idle(idle)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish, expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [11:0] rsp(input logic [7:0] d, input logic n, input logic t, input logic [1:0] tr);
        return {d, n, t, tr};
    endfunction

    // Offer one command, wait for acceptance, queue its expected response.
    task automatic send(input logic [6:0] a, input logic [4:0] mm, input logic rw,
                        input logic [7:0] d, input logic [11:0] e);
        int n = 0;
        cmd_addr  = a;
        cmd_mem   = mm;
        cmd_rw    = rw;
        cmd_data  = d;
        cmd_valid = 1'b1;
        while (!cmd_ready && n < 1000) begin
            tick();
            n++;
        end
        if (n >= 1000) begin
            checks++;
            errors++;
            $display("FAIL cmd_accept: got cmd_ready=0 for %0d cycles, expected acceptance", n);
        end
        exp_q.push_back(e);
        tick();
    endtask

    task automatic wait_done(input string name);
        int n = 0;
        while (!(exp_q.size() == 0 && idle && !m_busy) && n < 3000) begin
            tick();
            n++;
        end
        chk(name, 64'(n < 3000), 64'd1);
    endtask

    // Behavioural master: busy one cycle after en, held 4 cycles, then ack/data.
    initial begin
        m_busy    = 1'b0;
        m_ack_err = 1'b0;
        m_data_rd = 8'h00;
        forever begin
            tick();
            if (rst && m_en && mode != 1) begin
                tick();
                m_busy = 1'b1;
                if (mode == 2) begin
                    while (!stuck_release) tick();
                    m_ack_err = 1'b0;
                    m_busy    = 1'b0;
                end else begin
                    repeat (3) tick();
                    m_ack_err = (nack_left > 0);
                    if (nack_left > 0) nack_left--;
                    m_data_rd = rd_base ^ {3'b000, m_mem_addr};
                    m_busy    = 1'b0;
                end
            end
        end
    end

    // Scoreboard monitor: every presented response must equal the queue head.
    initial begin
        forever begin
            @(negedge clk);
            if (rst && rsp_valid) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL rsp_unexpected: got %0h expected no response",
                             {rsp_data, rsp_nack, rsp_timeout, rsp_tries});
                end else begin
                    chk("rsp_fields", 64'({rsp_data, rsp_nack, rsp_timeout, rsp_tries}), 64'(exp_q[0]));
                    if (rsp_ready) void'(exp_q.pop_front());
                end
            end
        end
    end

    // Enable monitor: count pulses; each must follow an idle, non-busy cycle.
    initial begin
        logic prev_en   = 1'b0;
        logic prev_busy = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                if (m_en) begin
                    en_cnt++;
                    chk("en_while_busy", 64'(m_busy), 64'd0);
                    chk("en_after_idle_cycle", 64'({prev_en, prev_busy}), 64'd0);
                end
                prev_en   = m_en;
                prev_busy = m_busy;
            end else begin
                prev_en   = 1'b0;
                prev_busy = 1'b0;
            end
        end
    end

    initial begin
        int n;
        int e0;
        rst       = 1'b1;
        cmd_valid = 1'b0;
        cmd_addr  = 7'd0;
        cmd_mem   = 5'd0;
        cmd_rw    = 1'b0;
        cmd_data  = 8'd0;
        rsp_ready = 1'b1;
        #3 rst = 1'b0;
        repeat (2) tick();
        chk("reset_outputs", 64'({cmd_ready, idle, rsp_valid, rsp_data, rsp_nack, rsp_timeout, rsp_tries,
                                  m_en, m_addr, m_mem_addr, m_rw, m_data_wr, fifo_level}), {24'd0, 2'b11, 38'd0});
        tick();
        rst = 1'b1;
        tick();

        // Write with ACK, including push-to-enable latency and held master fields.
        e0 = en_cnt;
        send(7'h2A, 5'h03, 1'b1, 8'hA5, rsp(8'h00, 1'b0, 1'b0, 2'd0));
        cmd_valid = 1'b0;
        chk("latency_no_en_after_push", 64'(m_en), 64'd0);
        tick();
        chk("latency_en_second_cycle", 64'(m_en), 64'd1);
        wait_done("t1_done");
        chk("t1_en_pulses", 64'(en_cnt - e0), 64'd1);
        chk("t1_fields_held", 64'({m_addr, m_mem_addr, m_rw, m_data_wr}), 64'({7'h2A, 5'h03, 1'b1, 8'hA5}));

        // Read held under back-pressure; a queued command must not issue.
        rsp_ready = 1'b0;
        e0 = en_cnt;
        send(7'h51, 5'h00, 1'b0, 8'hFF, rsp(8'h5C, 1'b0, 1'b0, 2'd0));
        cmd_valid = 1'b0;
        n = 0;
        while (!rsp_valid && n < 100) begin
            tick();
            n++;
        end
        chk("t2_rsp_arrives", 64'(rsp_valid), 64'd1);
        send(7'h33, 5'h10, 1'b1, 8'h3C, rsp(8'h00, 1'b0, 1'b0, 2'd0));
        cmd_valid = 1'b0;
        repeat (10) tick();
        chk("t2_no_issue_while_held", 64'(en_cnt - e0), 64'd1);
        chk("t2_level_while_held", 64'(fifo_level), 64'd1);
        chk("t2_valid_held", 64'(rsp_valid), 64'd1);
        rsp_ready = 1'b1;
        wait_done("t2_done");
        chk("t2_en_pulses", 64'(en_cnt - e0), 64'd2);

        // NACK on every attempt: 1 + RETRIES pulses, error response.
        nack_left = 99;
        e0 = en_cnt;
        send(7'h40, 5'h07, 1'b0, 8'h00, rsp(8'h00, 1'b1, 1'b0, 2'd2));
        cmd_valid = 1'b0;
        wait_done("t3_done");
        chk("t3_en_pulses", 64'(en_cnt - e0), 64'd3);
        nack_left = 0;

        // NACK once then ACK on the retry.
        nack_left = 1;
        e0 = en_cnt;
        send(7'h41, 5'h01, 1'b0, 8'h00, rsp(8'h5D, 1'b0, 1'b0, 2'd1));
        cmd_valid = 1'b0;
        wait_done("t4_done");
        chk("t4_en_pulses", 64'(en_cnt - e0), 64'd2);

        // Busy never rises: WAIT_BUSY lasts START_TO cycles, then RESP, then valid.
        mode = 1;
        m_ack_err = 1'b1;
        send(7'h42, 5'h02, 1'b0, 8'h00, rsp(8'h00, 1'b0, 1'b1, 2'd0));
        cmd_valid = 1'b0;
        n = 0;
        while (!m_en && n < 50) begin
            tick();
            n++;
        end
        n = 0;
        while (!rsp_valid && n < 400) begin
            tick();
            n++;
        end
        chk("start_timeout_cycles", 64'(n), 64'(START_TO + 2));
        mode = 0;
        wait_done("t5_done");

        // Busy stuck high: WAIT_DONE lasts DONE_TO cycles; next command waits for idle master.
        mode = 2;
        send(7'h43, 5'h04, 1'b1, 8'h99, rsp(8'h00, 1'b0, 1'b1, 2'd0));
        cmd_valid = 1'b0;
        n = 0;
        while (!m_en && n < 50) begin
            tick();
            n++;
        end
        n = 0;
        while (!rsp_valid && n < 600) begin
            tick();
            n++;
        end
        chk("done_timeout_cycles", 64'(n), 64'(DONE_TO + 3));
        e0 = en_cnt;
        send(7'h44, 5'h05, 1'b1, 8'h66, rsp(8'h00, 1'b0, 1'b0, 2'd0));
        cmd_valid = 1'b0;
        repeat (5) tick();
        chk("t6_hold_while_master_busy", 64'(en_cnt - e0), 64'd0);
        mode = 0;
        stuck_release = 1'b1;
        wait_done("t6_done");
        chk("t6_en_after_release", 64'(en_cnt - e0), 64'd1);
        chk("t6_fields_held", 64'({m_addr, m_mem_addr, m_rw, m_data_wr}), 64'({7'h44, 5'h05, 1'b1, 8'h66}));

        // DEPTH+1 back-to-back commands fill the FIFO; responses in order.
        e0 = en_cnt;
        send(7'h10, 5'h1F, 1'b1, 8'h11, rsp(8'h00, 1'b0, 1'b0, 2'd0));
        send(7'h11, 5'h01, 1'b0, 8'h00, rsp(8'h5D, 1'b0, 1'b0, 2'd0));
        send(7'h12, 5'h02, 1'b0, 8'h00, rsp(8'h5E, 1'b0, 1'b0, 2'd0));
        send(7'h13, 5'h03, 1'b1, 8'h22, rsp(8'h00, 1'b0, 1'b0, 2'd0));
        send(7'h14, 5'h04, 1'b0, 8'h00, rsp(8'h58, 1'b0, 1'b0, 2'd0));
        cmd_valid = 1'b0;
        chk("t7_cmd_ready_full", 64'(cmd_ready), 64'd0);
        chk("t7_level_full", 64'(fifo_level), 64'd4);
        wait_done("t7_done");
        chk("t7_level_empty", 64'(fifo_level), 64'd0);
        chk("t7_idle", 64'(idle), 64'd1);
        chk("t7_en_pulses", 64'(en_cnt - e0), 64'd5);

        // Asynchronous reset in WAIT_DONE with a command still queued.
        send(7'h60, 5'h08, 1'b1, 8'h01, rsp(8'h00, 1'b0, 1'b0, 2'd0));
        send(7'h61, 5'h09, 1'b1, 8'h02, rsp(8'h00, 1'b0, 1'b0, 2'd0));
        cmd_valid = 1'b0;
        n = 0;
        while (!m_busy && n < 50) begin
            tick();
            n++;
        end
        tick();
        tick();
        #2 rst = 1'b0;
        #1;
        chk("reset_async_outputs", 64'({cmd_ready, idle, rsp_valid, rsp_data, rsp_nack, rsp_timeout, rsp_tries,
                                        m_en, m_addr, m_mem_addr, m_rw, m_data_wr, fifo_level}), {24'd0, 2'b11, 38'd0});
        exp_q.delete();
        n = 0;
        while (m_busy && n < 50) begin
            tick();
            n++;
        end
        tick();
        rst = 1'b1;
        e0 = en_cnt;
        repeat (10) tick();
        chk("t8_no_issue_after_flush", 64'(en_cnt - e0), 64'd0);
        chk("t8_idle", 64'(idle), 64'd1);
        chk("t8_level", 64'(fifo_level), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/i2c_cmd_sequencer.md
Name: i2c_cmd_sequencer

Overview:
- Command front-end directly upstream of the team's I2C master.
- Accepts queued transaction requests (7-bit device address, 5-bit memory address, rw, write byte) over a valid/ready interface.
- Issues each request to the master's en/addr/mem_addr/rw/data_wr inputs and waits for the master's busy pulse to complete.
- Returns data_rd / ack_err as a response, with automatic retry on NACK and a hang timeout.

Parameters:
DEPTH, 4, command FIFO entries; power of 2, ≥2.
RETRIES, 2, extra attempts after a NACK before reporting error (0..3).
START_TO, 15, max cycles in WAIT_BUSY for m_busy to rise.
DONE_TO, 255, max cycles in WAIT_DONE for m_busy to fall.

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-low
cmd_valid  in  1  command offered
cmd_ready  out  1  FIFO not full
cmd_addr  in  7  target device address
cmd_mem  in  5  target memory address
cmd_rw  in  1  1 = write cmd_data, 0 = read one byte
cmd_data  in  8  write byte (ignored when cmd_rw=0)
rsp_valid  out  1  response held
rsp_ready  in  1  response consumed
rsp_data  out  8  read byte; 8'h00 for writes and failed transactions
rsp_nack  out  1  final attempt ended with ack_err=1
rsp_timeout  out  1  transaction aborted by timeout
rsp_tries  out  2  attempts used minus 1
m_en  out  1  to master en
m_addr  out  7  to master addr
m_mem_addr  out  5  to master mem_addr
m_rw  out  1  to master rw
m_data_wr  out  8  to master data_wr
m_data_rd  in  8  from master data_rd
m_ack_err  in  1  from master ack_err
m_busy  in  1  from master busy
fifo_level  out  clog2(DEPTH)+1  entries queued
idle  out  1  FIFO empty, FSM in IDLE, rsp_valid=0

Behaviour:
- Reset values:
  - All outputs 0 except cmd_ready=1 and idle=1.
  - FIFO empty, FSM IDLE, retry and timeout counters 0.
- Command FIFO:
  - Push when cmd_valid&&cmd_ready. cmd_ready = (level<DEPTH).
  - Pop only on the IDLE→ISSUE transition.
  - Simultaneous push and pop while full is not possible (ready=0). Simultaneous push and pop otherwise leaves level unchanged.
  - Pointers wrap modulo DEPTH.
- Master-side outputs:
  - m_addr/m_mem_addr/m_rw/m_data_wr are registered from the popped entry in the IDLE→ISSUE cycle.
  - They stay stable until the next pop; they are not cleared after completion.
- FSM:
  - IDLE: if FIFO non-empty and rsp_valid=0 → ISSUE (pop, load outputs, tries=0).
  - ISSUE: m_en=1 for exactly this one cycle → WAIT_BUSY; timer cleared.
  - WAIT_BUSY: m_busy=1 → WAIT_DONE, timer cleared. Timer reaching START_TO → RESP with timeout=1.
  - WAIT_DONE: m_busy=0 → CHECK. Timer reaching DONE_TO → RESP with timeout=1.
  - CHECK (1 cycle; lets the master's registered ack_err/data_rd settle):
    - m_ack_err=1 and tries<RETRIES → tries+1, → GAP.
    - Otherwise → RESP.
  - GAP: 1 idle cycle with m_en=0 (the master has just returned to idle) → ISSUE. Command fields are reused; no FIFO pop.
  - RESP: load response registers → IDLE.
    - rsp_valid=1.
    - rsp_nack=m_ack_err (0 on timeout).
    - rsp_timeout set per exit path.
    - rsp_tries=tries.
    - rsp_data = m_data_rd if m_rw=0 and no error, else 8'h00.
- Response:
  - rsp_valid holds, with fields stable, until rsp_ready is sampled high; it is then cleared next edge.
  - No new command issues while rsp_valid=1 (back-pressure through the FIFO).
- Latency: cmd accepted into an empty FIFO → m_en high 2 cycles later (push edge, IDLE→ISSUE edge).
- m_en is never asserted while m_busy=1.
- Timeout does not reset the master. The next command is still issued; if the master is still busy it is ignored until the master idles.
- Async reset mid-transaction:
  - m_en drops immediately and the FIFO is flushed.
  - Any in-flight response is lost.

Test Plan:
- Write cmd addr=7'h2A, mem=5'h03, rw=1, data=8'hA5; master model ACKs → m_en 1 cycle, outputs held; rsp_valid with nack=0, timeout=0, tries=0, data=8'h00.
- Read cmd; master model returns data_rd=8'h5C, ack_err=0 → rsp_data=8'h5C, tries=0; with rsp_ready held low for 10 cycles, response stays stable and no second m_en occurs.
- Master model NACKs every attempt, RETRIES=2 → exactly 3 m_en pulses, each separated by a busy period plus ≥1 GAP cycle; rsp_nack=1, tries=2, data=8'h00.
- NACK once then ACK → 2 m_en pulses, rsp_nack=0, tries=1.
- m_busy never rises → rsp_timeout=1 exactly START_TO cycles after WAIT_BUSY entry. Separately, m_busy stuck high → rsp_timeout=1 after DONE_TO cycles.
- Push DEPTH+1 commands back-to-back with rsp_ready=1 → cmd_ready low at level=DEPTH; all responses returned in order; fifo_level reaches 0; idle=1. Assert rst mid-WAIT_DONE → all outputs return to reset values asynchronously.
